// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: colour type, palettes, line timing and feeder FSM states.
// Used by the pixel feeder and by the downstream serializer.
package ws2812_pkg;

   typedef logic [23:0] grb_t;
   typedef logic [3:0][23:0] palette_t;

   localparam grb_t RED    = 24'hFF0000;
   localparam grb_t YELLOW = 24'hFFFF00;
   localparam grb_t GREEN  = 24'h00FF00;
   localparam grb_t BLUE   = 24'h0000FF;

   // Entry 0 sits in the least significant slot of each packed palette.
   localparam palette_t RING    = {GREEN, BLUE, YELLOW, RED};
   localparam palette_t UNIFORM = {BLUE, GREEN, YELLOW, RED};

   localparam int unsigned T0H_NS    = 400;
   localparam int unsigned T0L_NS    = 850;
   localparam int unsigned T1H_NS    = 800;
   localparam int unsigned T1L_NS    = 450;
   localparam int unsigned TRESET_US = 280;

   function automatic int unsigned ns_to_cycles(input int unsigned clk_hz,
                                                input int unsigned ns);
      return ((clk_hz / 1000) * ns + 999_999) / 1_000_000;
   endfunction

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } feed_state_t;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer on an active-low button followed by a restartable
// stability counter; the debounced level flips only after a full quiet window.
module button_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 100_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic button_n_i,
   output logic pressed_o
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             level_q;
   logic             level_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      // Any cycle where the input agrees with the output clears the count.
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= ~button_n_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pressed_o = level_q;

endmodule

// File: rtl/ws2812_pixel_feeder.sv
// Produces one frame of GRB pixel words per colour step over valid/ready.
// Frame content is frozen at frame start so late ticks or mode changes never tear a frame.
module ws2812_pixel_feeder
   import ws2812_pkg::*;
#(
   parameter int unsigned CLK_FREQ          = 10_000_000,
   parameter int unsigned NUM_LEDS          = 2,
   parameter int unsigned COLOR_STEP_CYCLES = CLK_FREQ,
   parameter int unsigned DEBOUNCE_CYCLES   = CLK_FREQ / 100
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        button1,
   output logic [23:0] pix_data,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic        pix_last,
   output logic        mode
);

   localparam int unsigned LED_W  = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
   localparam int unsigned STEP_W = (COLOR_STEP_CYCLES > 1) ? $clog2(COLOR_STEP_CYCLES) : 1;
   localparam logic [LED_W-1:0]  LED_LAST  = LED_W'(NUM_LEDS - 1);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(COLOR_STEP_CYCLES - 1);

   feed_state_t       state_q;
   feed_state_t       state_d;
   logic [STEP_W-1:0] step_cnt_q;
   logic [STEP_W-1:0] step_cnt_d;
   logic [1:0]        color_index_q;
   logic [1:0]        color_index_d;
   logic              frame_pending_q;
   logic              frame_pending_d;
   logic [1:0]        snap_index_q;
   logic [1:0]        snap_index_d;
   logic              snap_mode_q;
   logic              snap_mode_d;
   logic [LED_W-1:0]  led_idx_q;
   logic [LED_W-1:0]  led_idx_d;

   logic              step_tick;
   logic              last_led;
   logic [1:0]        ring_sel;
   grb_t              pixel_color;

   button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk        (clk),
      .rst_n      (rst_n),
      .button_n_i (button1),
      .pressed_o  (mode)
   );

   always_comb begin
      step_tick     = (step_cnt_q == STEP_LAST);
      step_cnt_d    = step_tick ? '0 : step_cnt_q + 1'b1;
      color_index_d = step_tick ? color_index_q + 2'd1 : color_index_q;
   end

   // Only the low two bits of the LED index matter for a 4-entry ring.
   always_comb begin
      last_led    = (led_idx_q == LED_LAST);
      ring_sel    = snap_index_q + 2'(led_idx_q);
      pixel_color = snap_mode_q ? UNIFORM[snap_index_q] : RING[ring_sel];
   end

   always_comb begin
      state_d         = state_q;
      led_idx_d       = led_idx_q;
      snap_index_d    = snap_index_q;
      snap_mode_d     = snap_mode_q;
      frame_pending_d = frame_pending_q;
      pix_valid       = 1'b0;
      pix_last        = 1'b0;
      pix_data        = '0;

      case (state_q)
         ST_IDLE: begin
            if (frame_pending_q) begin
               snap_index_d    = color_index_q;
               snap_mode_d     = mode;
               led_idx_d       = '0;
               frame_pending_d = 1'b0;
               state_d         = ST_STREAM;
            end
         end
         ST_STREAM: begin
            pix_valid = 1'b1;
            pix_last  = last_led;
            pix_data  = pixel_color;
            if (pix_ready) begin
               if (last_led) begin
                  state_d = ST_IDLE;
               end else begin
                  led_idx_d = led_idx_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A tick always wins over the clear at frame start, so it is never lost.
      if (step_tick) begin
         frame_pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= ST_IDLE;
         step_cnt_q      <= '0;
         color_index_q   <= '0;
         frame_pending_q <= 1'b1;
         snap_index_q    <= '0;
         snap_mode_q     <= 1'b0;
         led_idx_q       <= '0;
      end else begin
         state_q         <= state_d;
         step_cnt_q      <= step_cnt_d;
         color_index_q   <= color_index_d;
         frame_pending_q <= frame_pending_d;
         snap_index_q    <= snap_index_d;
         snap_mode_q     <= snap_mode_d;
         led_idx_q       <= led_idx_d;
      end
   end

endmodule

// File: tb/tb_ws2812_pixel_feeder.sv
// Directed bench for the WS2812 pixel feeder: two-LED chain for frame sequencing,
// stalls, debounce and reset; five- and one-LED chains for wrap and last-pixel cases.
module tb_ws2812_pixel_feeder;

   localparam logic [23:0] C_RED    = 24'hFF0000;
   localparam logic [23:0] C_YELLOW = 24'hFFFF00;
   localparam logic [23:0] C_GREEN  = 24'h00FF00;
   localparam logic [23:0] C_BLUE   = 24'h0000FF;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n_a, rst_n_b, button1, ready_a, ready_b;
   logic [23:0] data_a, data_b, data_c;
   logic        valid_a, valid_b, valid_c;
   logic        last_a, last_b, last_c;
   logic        mode_a, mode_b, mode_c;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   bit use_b  = 1'b0;

   logic        s_valid, s_last;
   logic [23:0] s_data;
   assign s_valid = use_b ? valid_b : valid_a;
   assign s_last  = use_b ? last_b  : last_a;
   assign s_data  = use_b ? data_b  : data_a;

   ws2812_pixel_feeder #(.CLK_FREQ(10_000_000), .NUM_LEDS(2), .COLOR_STEP_CYCLES(100), .DEBOUNCE_CYCLES(8)) u_dut_a (
      .clk(clk), .rst_n(rst_n_a), .button1(button1), .pix_data(data_a), .pix_valid(valid_a),
      .pix_ready(ready_a), .pix_last(last_a), .mode(mode_a));

   ws2812_pixel_feeder #(.CLK_FREQ(10_000_000), .NUM_LEDS(5), .COLOR_STEP_CYCLES(100), .DEBOUNCE_CYCLES(8)) u_dut_b (
      .clk(clk), .rst_n(rst_n_b), .button1(button1), .pix_data(data_b), .pix_valid(valid_b),
      .pix_ready(ready_b), .pix_last(last_b), .mode(mode_b));

   ws2812_pixel_feeder #(.CLK_FREQ(10_000_000), .NUM_LEDS(1), .COLOR_STEP_CYCLES(100), .DEBOUNCE_CYCLES(8)) u_dut_c (
      .clk(clk), .rst_n(rst_n_b), .button1(button1), .pix_data(data_c), .pix_valid(valid_c),
      .pix_ready(ready_b), .pix_last(last_c), .mode(mode_c));

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   // Waits (bounded) for a valid pixel on the selected chain, checks it, then lets it be accepted.
   task automatic get_pixel(input string tag, input logic [23:0] exp_data, input logic exp_last,
                            input int exp_cyc);
      int waited = 0;
      while (!s_valid && waited < 200) begin
         step();
         waited++;
      end
      check({tag, " valid"}, 32'(s_valid), 32'd1);
      check({tag, " cycle"}, 32'(cyc), 32'(exp_cyc));
      check({tag, " data"}, 32'(s_data), 32'(exp_data));
      check({tag, " last"}, 32'(s_last), 32'(exp_last));
      $display("pixel %s: data=%06h last=%0b cyc=%0d", tag, s_data, s_last, cyc);
      step();
   endtask

   logic [23:0] frame5_a [5];
   logic [23:0] frame5_b [5];

   initial begin
      frame5_a = '{C_RED, C_YELLOW, C_BLUE, C_GREEN, C_RED};
      frame5_b = '{C_YELLOW, C_BLUE, C_GREEN, C_RED, C_YELLOW};
      button1 = 1'b1;
      ready_a = 1'b1;
      ready_b = 1'b1;
      rst_n_a = 1'b0;
      rst_n_b = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset valid", 32'(valid_a), 32'd0);
      check("reset data", 32'(data_a), 32'd0);
      check("reset last", 32'(last_a), 32'd0);
      check("reset mode", 32'(mode_a), 32'd0);

      // Frame 0 right after release, then frame 1 on the first tick.
      rst_n_a = 1'b1;
      cyc = 0;
      get_pixel("f0p0", C_RED, 1'b0, 1);
      get_pixel("f0p1", C_YELLOW, 1'b1, 2);
      check("f0 idle valid", 32'(valid_a), 32'd0);
      get_pixel("f1p0", C_YELLOW, 1'b0, 101);
      get_pixel("f1p1", C_BLUE, 1'b1, 102);

      // Short bounce is rejected; a held press lands after DEBOUNCE+2 cycles.
      button1 = 1'b0;
      repeat (3) step();
      button1 = 1'b1;
      repeat (20) step();
      check("bounce mode", 32'(mode_a), 32'd0);
      button1 = 1'b0;
      repeat (9) step();
      check("mode before window", 32'(mode_a), 32'd0);
      step();
      check("mode after window", 32'(mode_a), 32'd1);
      get_pixel("f2p0", C_GREEN, 1'b0, 201);
      get_pixel("f2p1", C_GREEN, 1'b1, 202);
      button1 = 1'b1;
      repeat (15) step();
      check("mode released", 32'(mode_a), 32'd0);

      // Stall across the tick at 400; final handshake at 499 meets the tick at 500.
      get_pixel("f3p0", C_GREEN, 1'b0, 301);
      ready_a = 1'b0;
      while (cyc < 450) step();
      check("stall valid", 32'(valid_a), 32'd1);
      check("stall data", 32'(data_a), 32'(C_RED));
      check("stall last", 32'(last_a), 32'd1);
      while (cyc < 498) step();
      ready_a = 1'b1;
      get_pixel("f3p1", C_RED, 1'b1, 498);
      get_pixel("f4p0", C_RED, 1'b0, 500);
      get_pixel("f4p1", C_YELLOW, 1'b1, 501);
      get_pixel("f5p0", C_YELLOW, 1'b0, 503);
      check("f5p1 valid", 32'(valid_a), 32'd1);
      check("f5p1 data", 32'(data_a), 32'(C_BLUE));

      // Asynchronous reset mid-frame, then a fresh index-0 frame with a stalled first pixel.
      rst_n_a = 1'b0;
      #2;
      check("async rst valid", 32'(valid_a), 32'd0);
      check("async rst data", 32'(data_a), 32'd0);
      check("async rst last", 32'(last_a), 32'd0);
      step();
      step();
      ready_a = 1'b0;
      rst_n_a = 1'b1;
      cyc = 0;
      for (int k = 0; k < 5; k++) begin
         step();
         check("hold valid", 32'(valid_a), 32'd1);
         check("hold data", 32'(data_a), 32'(C_RED));
      end
      ready_a = 1'b1;
      get_pixel("r0p0", C_RED, 1'b0, 5);
      get_pixel("r0p1", C_YELLOW, 1'b1, 6);
      check("r0 idle valid", 32'(valid_a), 32'd0);
      get_pixel("r1p0", C_YELLOW, 1'b0, 101);
      get_pixel("r1p1", C_BLUE, 1'b1, 102);

      // Five-LED chain (wrap of ring offset and colour index) and one-LED chain.
      use_b = 1'b1;
      rst_n_b = 1'b1;
      cyc = 0;
      step();
      check("n1 valid", 32'(valid_c), 32'd1);
      check("n1 data", 32'(data_c), 32'(C_RED));
      check("n1 last", 32'(last_c), 32'd1);
      for (int k = 0; k < 5; k++)
         get_pixel($sformatf("n5f0p%0d", k), frame5_a[k], k == 4, 1 + k);
      check("n1 idle valid", 32'(valid_c), 32'd0);
      while (cyc < 101) step();
      check("n1 t1 data", 32'(data_c), 32'(C_YELLOW));
      check("n1 t1 last", 32'(last_c), 32'd1);
      for (int k = 0; k < 5; k++)
         get_pixel($sformatf("n5f1p%0d", k), frame5_b[k], k == 4, 101 + k);
      while (cyc < 401) step();
      for (int k = 0; k < 5; k++)
         get_pixel($sformatf("n5f4p%0d", k), frame5_a[k], k == 4, 401 + k);
      check("n5 mode", 32'(mode_b), 32'd0);
      check("n1 mode", 32'(mode_c), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
